// File: rtl/lp_rx_pkg.sv
// Shared LP line-state constants and LP receiver FSM encoding (TX LP sequencer uses the same constants).
// Escape states exist only when LP_RX_ESC_EN is defined.
package lp_rx_pkg;

   typedef logic [1:0] lp_line_t;

   // Line state is {P, N}.
   localparam lp_line_t LP00 = 2'b00;
   localparam lp_line_t LP01 = 2'b01;
   localparam lp_line_t LP10 = 2'b10;
   localparam lp_line_t LP11 = 2'b11;

   typedef enum logic [3:0] {
      ST_WAIT_STOP = 4'd0,
      ST_STOP      = 4'd1,
      ST_HS_RQST   = 4'd2,
      ST_HS_PREP   = 4'd3,
      ST_HS        = 4'd4
`ifdef LP_RX_ESC_EN
      ,
      ST_LP_RQST   = 4'd5,
      ST_ESC_BR    = 4'd6,
      ST_ESC_RQST  = 4'd7,
      ST_ESC       = 4'd8
`endif
   } lp_state_t;

endpackage

// File: rtl/lp_rx_filter.sv
// lp_filter: two-flop synchronizer per line plus dwell filter; emits the accepted
// line pair and a one-cycle strobe whenever the accepted pair changes.
module lp_filter
   import lp_rx_pkg::*;
#(
   parameter int T_MIN = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  lp_line_t pair,
   output lp_line_t line,
   output logic     chg
);

   lp_line_t   s1, s2;
   logic [1:0] vld_pipe;
   logic [3:0] dwell;
   logic       acc_vld;
   logic       stable;

   // vld_pipe keeps the preset synchronizer contents out of the dwell count,
   // so post-reset acceptance sees the same latency as a real line edge.
   assign stable = vld_pipe[1] && (dwell >= 4'(T_MIN - 1)) && (!acc_vld || s2 != line);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1       <= LP11;
         s2       <= LP11;
         vld_pipe <= '0;
         dwell    <= '0;
         line     <= LP00;
         acc_vld  <= 1'b0;
         chg      <= 1'b0;
      end else begin
         s1       <= pair;
         s2       <= s1;
         vld_pipe <= {vld_pipe[0], 1'b1};
         if (!vld_pipe[1] || s1 != s2)
            dwell <= '0;
         else if (dwell != 4'hF)
            dwell <= dwell + 4'd1;
         chg <= stable;
         if (stable) begin
            line    <= s2;
            acc_vld <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/lp_rx.sv
// D-PHY style LP receiver: filtered line states drive the STOP/HS-entry FSM.
// Define LP_RX_ESC_EN to build the escape-mode entry path.
module lp_rx
   import lp_rx_pkg::*;
#(
   parameter int T_MIN    = 4,
   parameter int T_SETTLE = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic lp_p,
   input  logic lp_n,
   output logic stop_state,
   output logic hs_term_en,
   output logic hs_rx_en,
   output logic esc_mode,
   output logic lp_err
);

   lp_line_t   line;
   logic       chg;
   lp_state_t  state, state_n;
   logic [3:0] settle, settle_n;
   logic       err_n;

   lp_filter #(.T_MIN(T_MIN)) u_filter (
      .clk  (clk),
      .rst  (rst),
      .pair ({lp_p, lp_n}),
      .line (line),
      .chg  (chg)
   );

   always_comb begin
      state_n  = state;
      settle_n = (state == ST_HS_PREP && settle != 4'd0) ? settle - 4'd1 : 4'd0;
      err_n    = 1'b0;
      if (chg) begin
         if (line == LP11) begin
            state_n = ST_STOP;
         end else begin
            case (state)
               ST_WAIT_STOP: ;
               ST_STOP:
                  if (line == LP01) state_n = ST_HS_RQST;
`ifdef LP_RX_ESC_EN
                  else if (line == LP10) state_n = ST_LP_RQST;
`endif
                  else err_n = 1'b1;
               ST_HS_RQST:
                  if (line == LP00) begin
                     state_n  = ST_HS_PREP;
                     settle_n = 4'(T_SETTLE);
                  end else err_n = 1'b1;
`ifdef LP_RX_ESC_EN
               ST_LP_RQST:
                  if (line == LP00) state_n = ST_ESC_BR;
                  else err_n = 1'b1;
               ST_ESC_BR:
                  if (line == LP01) state_n = ST_ESC_RQST;
                  else err_n = 1'b1;
               ST_ESC_RQST:
                  if (line == LP00) state_n = ST_ESC;
                  else err_n = 1'b1;
`endif
               default: err_n = 1'b1;
            endcase
            if (err_n) state_n = ST_WAIT_STOP;
         end
      end else if (state == ST_HS_PREP && line == LP00 && settle <= 4'd1) begin
         // Settle counter hits zero on this edge.
         state_n = ST_HS;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_WAIT_STOP;
         settle     <= '0;
         stop_state <= 1'b0;
         hs_term_en <= 1'b0;
         hs_rx_en   <= 1'b0;
         lp_err     <= 1'b0;
      end else begin
         state      <= state_n;
         settle     <= settle_n;
         stop_state <= (state_n == ST_STOP);
         hs_term_en <= (state_n == ST_HS_PREP) || (state_n == ST_HS);
         hs_rx_en   <= (state_n == ST_HS);
         lp_err     <= err_n;
      end
   end

`ifdef LP_RX_ESC_EN
   always_ff @(posedge clk) begin
      if (rst) esc_mode <= 1'b0;
      else     esc_mode <= (state_n == ST_ESC);
   end
`else
   assign esc_mode = 1'b0;
`endif

endmodule

// File: tb/tb_lp_rx.sv
// Directed + randomized bench for lp_rx; every cycle is compared against a window-based
// reference model of line acceptance and a rule table of the LP protocol.
module tb_lp_rx;

   localparam int T_MIN    = 4;
   localparam int T_SETTLE = 8;
   localparam logic [1:0] L00 = 2'b00, L01 = 2'b01, L10 = 2'b10, L11 = 2'b11;
   localparam int S_ERR = -1, S_WAIT = 0, S_STOP = 1, S_HSRQ = 2, S_PREP = 3, S_HS = 4,
                  S_LPRQ = 5, S_BR = 6, S_ESRQ = 7, S_ESC = 8;

   logic clk = 1'b0, rst = 1'b1, lp_p = 1'b1, lp_n = 1'b1;
   logic stop_state, hs_term_en, hs_rx_en, esc_mode, lp_err;

   always #5 clk = ~clk;

   lp_rx #(.T_MIN(T_MIN), .T_SETTLE(T_SETTLE)) dut (
      .clk(clk), .rst(rst), .lp_p(lp_p), .lp_n(lp_n),
      .stop_state(stop_state), .hs_term_en(hs_term_en), .hs_rx_en(hs_rx_en),
      .esc_mode(esc_mode), .lp_err(lp_err)
   );

   int checks = 0, errors = 0;
   int cyc = 0;

   // Reference model: line samples since reset, accepted value, protocol state.
   logic [1:0] hist[$];
   int         m_edge, m_st, m_prep_edge;
   logic [1:0] m_acc, m_pend_line;
   bit         m_acc_vld, m_pend;
   bit         e_stop, e_term, e_rx, e_esc, e_err;

   function automatic int rule(int st, logic [1:0] l);
      if (l == L11) return S_STOP;
      if (st == S_WAIT) return S_WAIT;
      if (st == S_STOP && l == L01) return S_HSRQ;
      if (st == S_HSRQ && l == L00) return S_PREP;
`ifdef LP_RX_ESC_EN
      if (st == S_STOP && l == L10) return S_LPRQ;
      if (st == S_LPRQ && l == L00) return S_BR;
      if (st == S_BR   && l == L01) return S_ESRQ;
      if (st == S_ESRQ && l == L00) return S_ESC;
`endif
      return S_ERR;
   endfunction

   function automatic void model_edge(bit r, logic [1:0] in);
      int  lo, nx;
      bit  same;
      e_err = 1'b0;
      if (r) begin
         hist.delete();
         m_edge = 0; m_st = S_WAIT; m_acc_vld = 1'b0; m_pend = 1'b0; m_acc = L00;
      end else begin
         m_edge++;
         // A change accepted on the previous edge drives the protocol on this one.
         if (m_pend) begin
            nx = rule(m_st, m_pend_line);
            if (nx == S_ERR) begin
               m_st  = S_WAIT;
               e_err = 1'b1;
            end else begin
               if (nx == S_PREP && m_st != S_PREP) m_prep_edge = m_edge;
               m_st = nx;
            end
         end else if (m_st == S_PREP && m_edge - m_prep_edge >= T_SETTLE) begin
            m_st = S_HS;
         end
         m_pend = 1'b0;
         hist.push_back(in);
         // Accepted once T_MIN post-reset samples, ending two sync stages ago, agree.
         lo = m_edge - T_MIN - 2;
         if (lo >= 0) begin
            same = 1'b1;
            for (int k = lo; k <= m_edge - 3; k++)
               if (hist[k] != hist[lo]) same = 1'b0;
            if (same && (!m_acc_vld || hist[lo] != m_acc)) begin
               m_acc = hist[lo]; m_acc_vld = 1'b1;
               m_pend = 1'b1; m_pend_line = hist[lo];
            end
         end
      end
      e_stop = (m_st == S_STOP);
      e_term = (m_st == S_PREP) || (m_st == S_HS);
      e_rx   = (m_st == S_HS);
      e_esc  = (m_st == S_ESC);
   endfunction

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d: got %b expected %b", tag, cyc, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   int  stop_rise, term_rise, rx_rise;
   bit  prev_stop, prev_term, prev_rx;

   task automatic step(input logic [1:0] l, input int n);
      for (int i = 0; i < n; i++) begin
         lp_p = l[1];
         lp_n = l[0];
         @(posedge clk);
         model_edge(rst, l);
         cyc++;
         #1;
         chk("stop_state", stop_state, e_stop);
         chk("hs_term_en", hs_term_en, e_term);
         chk("hs_rx_en",   hs_rx_en,   e_rx);
         chk("esc_mode",   esc_mode,   e_esc);
         chk("lp_err",     lp_err,     e_err);
         if (stop_state && !prev_stop) stop_rise = cyc;
         if (hs_term_en && !prev_term) term_rise = cyc;
         if (hs_rx_en   && !prev_rx)   rx_rise   = cyc;
         prev_stop = stop_state; prev_term = hs_term_en; prev_rx = hs_rx_en;
      end
   endtask

   int rel;
   logic [1:0] rl;

   initial begin
      // Reset, then LP11 held: STOP after 2 sync + T_MIN + 1 output cycles.
      rst = 1'b1;
      step(L11, 3);
      rst = 1'b0;
      rel = cyc;
      step(L11, 10);
      chk_int("stop_latency", stop_rise - rel, 2 + T_MIN + 1);

      // HS entry and exit.
      step(L01, 6);
      step(L00, 20);
      chk_int("settle_gap", rx_rise - term_rise, T_SETTLE);
      step(L11, 8);

      // Short glitch in STOP is ignored.
      step(L01, 2);
      step(L11, 6);
      step(L01, T_MIN - 1);
      step(L11, 6);

      // Abort HS request back to STOP, then an illegal sequence.
      step(L01, 6);
      step(L11, 6);
      step(L01, 6);
      step(L10, 8);
      step(L11, 8);

      // Escape entry (error on LP10 when escape is not built).
      step(L10, 6);
      step(L00, 6);
      step(L01, 6);
      step(L00, 6);
      step(L11, 8);

      // Reset in the middle of HS.
      step(L01, 6);
      step(L00, 20);
      chk("hs_before_rst", hs_rx_en, 1'b1);
      rst = 1'b1;
      step(L11, 1);
      rst = 1'b0;
      rel = cyc;
      step(L11, 10);
      chk_int("stop_after_rst", stop_rise - rel, 2 + T_MIN + 1);

      // Randomized segments: noise, glitches, legal HS bursts, escape attempts, resets.
      for (int it = 0; it < 80; it++) begin
         case ($urandom_range(0, 4))
            0: begin
               rl = 2'($urandom_range(0, 3));
               step(rl, $urandom_range(1, 9));
            end
            1: begin
               rl = 2'($urandom_range(0, 3));
               step(rl, $urandom_range(1, T_MIN - 1));
            end
            2: begin
               step(L11, $urandom_range(T_MIN, 8));
               step(L01, $urandom_range(T_MIN, 8));
               step(L00, $urandom_range(2, 20));
               step(L11, $urandom_range(1, 8));
            end
            3: begin
               step(L11, $urandom_range(T_MIN, 8));
               step(L10, $urandom_range(T_MIN, 7));
               step(L00, $urandom_range(T_MIN, 7));
               step(L01, $urandom_range(T_MIN, 7));
               step(L00, $urandom_range(T_MIN, 7));
            end
            default: begin
               rst = 1'b1;
               step(L11, $urandom_range(1, 3));
               rst = 1'b0;
            end
         endcase
      end
      step(L11, 10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
